// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer, the array and its bench.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package systolic_pkg;

    localparam int MAX_SIZE = 32;                       // largest square dimension N
    localparam int SEL_BITS = 3;                        // size code width (array XYZ port)
    localparam int IDX_BITS = $clog2(MAX_SIZE);         // operand read-index width
    localparam int CNT_BITS = $clog2(2*MAX_SIZE) + 1;   // phase counter width
    localparam int I_BITS   = 8;                        // array operand width
    localparam int O_BITS   = 32;                       // array accumulator width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // N = 2^(sel+1), built in the counter width so 2N still fits.
    function automatic logic [CNT_BITS-1:0] size_from_sel(input logic [SEL_BITS-1:0] sel);
        logic [CNT_BITS-1:0] one;
        one = {{(CNT_BITS-1){1'b0}}, 1'b1};
        return one << (int'(sel) + 1);
    endfunction

    // Legal codes give N = 4 .. MAX_SIZE.
    function automatic logic sel_is_legal(input logic [SEL_BITS-1:0] sel);
        return (int'(sel) >= 1) && (int'(sel) <= $clog2(MAX_SIZE) - 1);
    endfunction

endpackage

// File: rtl/systolic_job_sequencer.sv
// Sequences one matrix-multiply job: clear, N operand feed cycles, 2N-1 drain cycles, done pulse.
// Latency: o_done is high 3N+1 edges after the accepted start edge, +1 per feed stall cycle.
// Backpressure: i_feed_ready low during FEED stalls the feed (valid low, index held); no timeout.
//
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_start, i_size_sel, i_abort      host request / size code / cancel
//   i_feed_ready                      operand buffers hold data for the current index
//   o_busy                            job in progress
//   o_sa_clear, o_sa_valid, o_sa_xyz  array clear / advance / latched size code
//   o_zero_ops                        force array operands to zero while draining
//   o_rd_en, o_rd_idx                 operand buffer pop strobe and index
//   o_done, o_err                     result-valid pulse / illegal size code pulse
module systolic_job_sequencer #(
    parameter int MAX_SIZE = systolic_pkg::MAX_SIZE,
    parameter int SEL_BITS = systolic_pkg::SEL_BITS,
    parameter int IDX_BITS = $clog2(MAX_SIZE),
    parameter int CNT_BITS = $clog2(2*MAX_SIZE) + 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [SEL_BITS-1:0] i_size_sel,
    input  logic                i_abort,
    input  logic                i_feed_ready,
    output logic                o_busy,
    output logic                o_sa_clear,
    output logic                o_sa_valid,
    output logic [SEL_BITS-1:0] o_sa_xyz,
    output logic                o_zero_ops,
    output logic                o_rd_en,
    output logic [IDX_BITS-1:0] o_rd_idx,
    output logic                o_done,
    output logic                o_err
);
    import systolic_pkg::*;

    // An instance built for a smaller array also rejects codes above its own size.
    localparam int MAX_SEL = $clog2(MAX_SIZE) - 1;

    state_t              state_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [IDX_BITS-1:0] idx_q;      // next operand index to pop
    logic                busy_q;
    logic                clear_q;
    logic                valid_q;
    logic                zero_q;
    logic                rd_en_q;
    logic [IDX_BITS-1:0] rd_idx_q;
    logic                done_q;
    logic                err_q;
    logic [SEL_BITS-1:0] xyz_q;

    logic [CNT_BITS-1:0] n_size_d;
    logic [CNT_BITS-1:0] feed_reload_d;
    logic [CNT_BITS-1:0] drain_reload_d;
    logic                start_d;
    logic                sel_ok_d;

    always_comb begin
        n_size_d       = size_from_sel(xyz_q);
        feed_reload_d  = n_size_d - CNT_BITS'(1);
        drain_reload_d = (n_size_d << 1) - CNT_BITS'(2);
        // o_busy stays high through the done pulse, so a start in that cycle is dropped.
        start_d        = i_start && !busy_q;
        sel_ok_d       = sel_is_legal(i_size_sel) && (int'(i_size_sel) <= MAX_SEL);
    end

    // Outputs are registered from the state being left, so they trail the state by one edge.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            clear_q  <= 1'b0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            rd_idx_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            xyz_q    <= '0;
        end else begin
            busy_q   <= 1'b0;
            clear_q  <= 1'b0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            rd_idx_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;

            if (state_q != ST_IDLE && i_abort) begin
                // Abort beats everything, including a pending done and a start in the same cycle.
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                idx_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_d) begin
                            if (sel_ok_d) begin
                                xyz_q   <= i_size_sel;
                                busy_q  <= 1'b1;
                                state_q <= ST_CLEAR;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    ST_CLEAR: begin
                        busy_q  <= 1'b1;
                        clear_q <= 1'b1;
                        idx_q   <= '0;
                        cnt_q   <= feed_reload_d;
                        state_q <= ST_FEED;
                    end
                    ST_FEED: begin
                        busy_q   <= 1'b1;
                        rd_en_q  <= i_feed_ready;
                        valid_q  <= i_feed_ready;
                        rd_idx_q <= idx_q;
                        if (i_feed_ready) begin
                            if (cnt_q == '0) begin
                                idx_q   <= '0;
                                cnt_q   <= drain_reload_d;
                                state_q <= ST_DRAIN;
                            end else begin
                                idx_q <= idx_q + IDX_BITS'(1);
                                cnt_q <= cnt_q - CNT_BITS'(1);
                            end
                        end
                    end
                    ST_DRAIN: begin
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        zero_q  <= 1'b1;
                        if (cnt_q == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q - CNT_BITS'(1);
                        end
                    end
                    ST_DONE: begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_busy     = busy_q;
    assign o_sa_clear = clear_q;
    assign o_sa_valid = valid_q;
    assign o_sa_xyz   = xyz_q;
    assign o_zero_ops = zero_q;
    assign o_rd_en    = rd_en_q;
    assign o_rd_idx   = rd_idx_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_systolic_job_sequencer.sv
// Self-checking bench for systolic_job_sequencer: job schedules predicted from the phase rules.
// Latency: n/a.
// Backpressure: feed-ready stalls driven from fixed and random patterns.
module tb_systolic_job_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] size_sel;
    logic       abort_r;
    logic       feed_ready;
    logic       busy, sa_clear, sa_valid, zero_ops, rd_en, done, err;
    logic [2:0] sa_xyz;
    logic [4:0] rd_idx;

    always #5 clk = ~clk;

    systolic_job_sequencer dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_start      (start),
        .i_size_sel   (size_sel),
        .i_abort      (abort_r),
        .i_feed_ready (feed_ready),
        .o_busy       (busy),
        .o_sa_clear   (sa_clear),
        .o_sa_valid   (sa_valid),
        .o_sa_xyz     (sa_xyz),
        .o_zero_ops   (zero_ops),
        .o_rd_en      (rd_en),
        .o_rd_idx     (rd_idx),
        .o_done       (done),
        .o_err        (err)
    );

    // {busy, clear, valid, zero_ops, rd_en, done, err, rd_idx[4:0]}
    logic [11:0] obs;
    assign obs = {busy, sa_clear, sa_valid, zero_ops, rd_en, done, err, rd_idx};

    localparam logic [11:0] M_ALL   = 12'hFFF;
    localparam logic [11:0] M_NOIDX = 12'hFE0;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [2:0] last_xyz = 3'd0;

    // Predicts the whole job from the phase rules, then drives it and compares cycle by cycle.
    task automatic run_job(input logic [2:0] sel, input int stall_pct, input int stall_idx,
                           input int stall_len, input int abort_k, input int busy_start_k);
        int          n, pops, k, stalled, stalls, done_k;
        logic        r;
        logic        ready_at [0:255];
        logic [11:0] exp_q [$];
        logic [11:0] msk_q [$];
        n       = 1 << (int'(sel) + 1);
        pops    = 0;
        stalled = 0;
        stalls  = 0;
        // edge 0: start accepted, only busy visible
        ready_at[0] = 1'b0;
        exp_q.push_back(12'h800); msk_q.push_back(M_NOIDX);
        // edge 1: one clear cycle
        ready_at[1] = 1'($urandom_range(1, 0));
        exp_q.push_back(12'hC00); msk_q.push_back(M_NOIDX);
        k = 2;
        while (pops < n) begin
            if (pops == stall_idx && stalled < stall_len) begin
                r = 1'b0;
                stalled++;
            end else if (stall_pct > 0 && k < 120 && $urandom_range(99, 0) < stall_pct) begin
                r = 1'b0;
            end else begin
                r = 1'b1;
            end
            if (!r) stalls++;
            ready_at[k] = r;
            exp_q.push_back({1'b1, 1'b0, r, 1'b0, r, 1'b0, 1'b0, 5'(pops)});
            msk_q.push_back(M_ALL);
            if (r) pops++;
            k++;
        end
        for (int i = 0; i < 2*n - 1; i++) begin
            ready_at[k] = 1'($urandom_range(1, 0));  // ignored while draining
            exp_q.push_back(12'hB00); msk_q.push_back(M_NOIDX);
            k++;
        end
        ready_at[k] = 1'($urandom_range(1, 0));
        exp_q.push_back(12'h840); msk_q.push_back(M_NOIDX);
        k++;
        ready_at[k] = 1'($urandom_range(1, 0));
        exp_q.push_back(12'h000); msk_q.push_back(M_NOIDX);

        @(negedge clk);
        start      = 1'b1;
        size_sel   = sel;
        feed_ready = 1'($urandom_range(1, 0));
        abort_r    = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ((obs & msk_q[0]) !== exp_q[0]) $display("FAIL job_start k=0 obs=%h exp=%h", obs & msk_q[0], exp_q[0]);
        else n_pass++;
        n_checks++;
        if (sa_xyz !== sel) $display("FAIL xyz_latch obs=%0d exp=%0d", sa_xyz, sel);
        else n_pass++;
        last_xyz = sel;

        done_k = -1;
        for (int kk = 1; kk < exp_q.size(); kk++) begin
            @(negedge clk);
            start      = (kk == busy_start_k) || (kk == abort_k);
            size_sel   = (sel == 3'd1) ? 3'd2 : 3'd1;
            abort_r    = (kk == abort_k);
            feed_ready = ready_at[kk];
            @(posedge clk); #1;
            if (kk == abort_k) begin
                n_checks++;
                if ((obs & M_NOIDX) !== 12'h000) $display("FAIL abort_drop k=%0d obs=%h exp=000", kk, obs & M_NOIDX);
                else n_pass++;
                break;
            end
            n_checks++;
            if ((obs & msk_q[kk]) !== exp_q[kk]) $display("FAIL job_trace sel=%0d k=%0d obs=%h exp=%h", sel, kk, obs & msk_q[kk], exp_q[kk]);
            else n_pass++;
            if (done === 1'b1 && done_k < 0) done_k = kk;
        end

        @(negedge clk);
        start   = 1'b0;
        abort_r = 1'b0;
        if (abort_k > 0) begin
            for (int i = 0; i < 2*n; i++) begin
                @(posedge clk); #1;
                n_checks++;
                if ((obs & M_NOIDX) !== 12'h000) $display("FAIL after_abort i=%0d obs=%h exp=000", i, obs & M_NOIDX);
                else n_pass++;
            end
        end else begin
            n_checks++;
            if (done_k !== 3*n + 1 + stalls) $display("FAIL done_latency sel=%0d obs=%0d exp=%0d", sel, done_k, 3*n + 1 + stalls);
            else n_pass++;
        end
        n_checks++;
        if (sa_xyz !== sel) $display("FAIL xyz_hold obs=%0d exp=%0d", sa_xyz, sel);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; size_sel = 3'd0; abort_r = 1'b0; feed_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 12'h000) $display("FAIL reset_outputs obs=%h exp=000", obs);
        else n_pass++;
        n_checks++;
        if (sa_xyz !== 3'd0) $display("FAIL reset_xyz obs=%0d exp=0", sa_xyz);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== 12'h000) $display("FAIL idle_after_reset obs=%h exp=000", obs);
        else n_pass++;
    endtask

    task automatic test_n4();
        run_job(3'd1, 0, -1, 0, 0, 0);
    endtask

    task automatic test_n32();
        run_job(3'd4, 0, -1, 0, 0, 0);
    endtask

    task automatic test_stall();
        run_job(3'd1, 0, 2, 3, 0, 0);
    endtask

    task automatic test_illegal_sel();
        logic [2:0] bad [4];
        bad[0] = 3'd0; bad[1] = 3'd5; bad[2] = 3'd6; bad[3] = 3'd7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start    = 1'b1;
            size_sel = bad[i];
            @(posedge clk); #1;
            n_checks++;
            if (err !== 1'b1 || busy !== 1'b0) $display("FAIL illegal_err sel=%0d err=%b busy=%b exp err=1 busy=0", bad[i], err, busy);
            else n_pass++;
            n_checks++;
            if (sa_xyz !== last_xyz) $display("FAIL illegal_xyz sel=%0d obs=%0d exp=%0d", bad[i], sa_xyz, last_xyz);
            else n_pass++;
            @(negedge clk);
            start = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (obs !== 12'h000) $display("FAIL illegal_pulse_len sel=%0d obs=%h exp=000", bad[i], obs);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        // N=8: drain occupies edges 10..24; abort at 15 with a start in the same cycle,
        // and a stray start at edge 4 while feeding.
        run_job(3'd2, 0, -1, 0, 15, 4);
        run_job(3'd1, 0, -1, 0, 0, 0);
    endtask

    task automatic test_reset_mid_job();
        @(negedge clk);
        start      = 1'b1;
        size_sel   = 3'd3;
        feed_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 12'h000) $display("FAIL async_reset_outputs obs=%h exp=000", obs);
        else n_pass++;
        n_checks++;
        if (sa_xyz !== 3'd0) $display("FAIL async_reset_xyz obs=%0d exp=0", sa_xyz);
        else n_pass++;
        last_xyz = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_job(3'd2, 0, -1, 0, 0, 0);
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 6; j++) begin
            run_job(3'($urandom_range(4, 1)), 25, -1, 0, 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        run_job(3'd2, 10, -1, 0, 0, 0);
        run_job(3'd3, 0, 5, 2, 0, 0);
    endtask

    initial begin
        test_reset();
        test_n4();
        test_n32();
        test_stall();
        test_illegal_sel();
        test_abort();
        test_reset_mid_job();
        test_random_jobs();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
